fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_VECTOR, default '0 (ARCH bits), PC value loaded on reset.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 redirect_in  input  1  branch/jump redirect request, single-cycle pulse or level.
REQ-005 redirect_addr_in  input  ARCH  redirect target address.
REQ-006 imem_req_out  output  1  instruction memory request.
REQ-007 imem_addr_out  output  ARCH  request address, equals current PC.
REQ-008 imem_gnt_in  input  1  memory accepted request this cycle.
REQ-009 imem_rvalid_in  input  1  read data valid, never in same cycle as its gnt.
REQ-010 imem_rdata_in  input  32  instruction word.
REQ-011 instr_valid_out  output  1  fetched instruction available to decode.
REQ-012 instr_ready_in  input  1  decode accepts instruction.
REQ-013 instr_out  output  32  held instruction word.
REQ-014 instr_pc_out  output  ARCH  PC of held instruction.
REQ-015 instr_pc_incr_out  output  ARCH  instr_pc_out + ARCH_BYTES, for JAL link.
REQ-016 misalign_out  output  1  pulse: redirect target not ARCH_BYTES-aligned.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD.
REQ-018 IDLE -> REQ unconditionally next cycle; IDLE asserts no outputs.
REQ-019 REQ: imem_req_out=1, imem_addr_out=pc; on imem_gnt_in -> WAIT; address SHALL stay stable until gnt unless redirected.
REQ-020 WAIT: on imem_rvalid_in capture rdata, pc, pc+ARCH_BYTES into output register -> HOLD; pc <= pc + ARCH_BYTES.
REQ-021 HOLD: instr_valid_out=1; on instr_ready_in -> REQ; outputs stable while not accepted.
REQ-022 Fetch latency: instruction visible one cycle after rvalid; minimum 3 cycles per instruction.
REQ-023 Redirect in REQ without gnt: pc <= redirect_addr_in, stay REQ, new address next cycle.
REQ-024 Redirect in REQ with gnt same cycle: pc <= redirect_addr_in, set kill flag, -> WAIT.
REQ-025 Redirect in WAIT: pc <= redirect_addr_in, set kill flag; response on rvalid discarded, -> REQ, kill cleared.
REQ-026 Redirect in HOLD: instr_valid_out drops next cycle, pc <= redirect_addr_in, -> REQ; simultaneous ready counts as accepted, redirect still wins.
REQ-027 Redirect in IDLE: pc <= redirect_addr_in, -> REQ.
REQ-028 Redirect with misaligned target: misalign_out=1 for one cycle, low log2(ARCH_BYTES) bits of target forced to 0.
REQ-029 PC arithmetic modulo 2^ARCH; 0xFFFFFFFC + 4 wraps to 0 with no flag.
REQ-030 Killed response SHALL never assert instr_valid_out.

Reset
REQ-031 On rst: state IDLE, pc=RESET_VECTOR, kill=0, imem_req_out=0, instr_valid_out=0, misalign_out=0, instr_out=0, instr_pc_out=0, instr_pc_incr_out=0.
REQ-032 rst mid-transaction SHALL abandon outstanding request; a late rvalid after reset SHALL be ignored (accepted only in WAIT).

Structure
REQ-033 ARCH, ARCH_BYTES and fetch state enum (fetch_state_t) SHALL live in friscv_pkg.
REQ-034 Output holding register SHALL be one sub-module, fetch_buf (data, pc, pc_incr, valid).
REQ-035 Existing mux_2_way SHALL select next pc (sequential vs redirect).

Verification
REQ-036 Reset, gnt and rvalid each 1 cycle late -> first imem_addr_out=RESET_VECTOR, instr_pc_out=0x0, instr_pc_incr_out=0x4.
REQ-037 Ready held low 5 cycles in HOLD -> instr_out/instr_pc_out unchanged, no new imem_req_out.
REQ-038 Redirect to 0x100 during WAIT -> response discarded, next imem_addr_out=0x100, no instr_valid_out for old word.
REQ-039 Redirect to 0x202 -> misalign_out pulse, next imem_addr_out=0x200.
REQ-040 pc=0xFFFFFFFC fetched -> next imem_addr_out=0x0, instr_pc_incr_out=0x0.
REQ-041 rst asserted in WAIT then rvalid -> no instr_valid_out, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/friscv_pkg.sv
// Shared architecture constants and fetch-stage types for the friscv core.
package friscv_pkg;

    localparam int ARCH       = 32;
    localparam int ARCH_BYTES = ARCH / 8;
    localparam int ALIGN_BITS = $clog2(ARCH_BYTES);

    localparam logic [ARCH-1:0] PC_STEP = ARCH'(ARCH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Clears the sub-word offset so a target always lands on an instruction boundary.
    function automatic logic [ARCH-1:0] align_addr(input logic [ARCH-1:0] addr);
        return {addr[ARCH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Output holding register for one fetched instruction: word, its PC and PC + one word.
module fetch_buf
    import friscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     data_in,
    input  logic [ARCH-1:0] pc_in,
    output logic            valid,
    output logic [31:0]     data,
    output logic [ARCH-1:0] pc,
    output logic [ARCH-1:0] pc_incr
);

    // Contents are kept after clear so the outputs only move on a new load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            pc      <= '0;
            pc_incr <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            data    <= data_in;
            pc      <= pc_in;
            pc_incr <= pc_in + PC_STEP;
        end else if (clear) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_2_way.sv
// Generic two-input multiplexer: y = sel ? d1 : d0.
module mux_2_way #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect/kill handling,
// and a single-entry holding register towards decode.
module fetch_ctrl
    import friscv_pkg::*;
#(
    parameter logic [ARCH-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_in,
    input  logic [ARCH-1:0] redirect_addr_in,
    output logic            imem_req_out,
    output logic [ARCH-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [31:0]     imem_rdata_in,
    output logic            instr_valid_out,
    input  logic            instr_ready_in,
    output logic [31:0]     instr_out,
    output logic [ARCH-1:0] instr_pc_out,
    output logic [ARCH-1:0] instr_pc_incr_out,
    output logic            misalign_out,
    output fetch_state_t    dbg_state_out
);

    // Handshakes: imem request completes in the cycle imem_req_out && imem_gnt_in; its
    // data returns on a later imem_rvalid_in. An instruction transfers to decode in the
    // cycle instr_valid_out && instr_ready_in; outputs hold steady until that cycle.

    fetch_state_t    state;
    logic [ARCH-1:0] pc;
    logic            kill;
    logic            req_q;
    logic            misalign_q;

    logic [ARCH-1:0] pc_seq;
    logic [ARCH-1:0] pc_target;
    logic [ARCH-1:0] pc_next;
    logic            buf_load;
    logic            buf_clear;

    assign pc_seq    = pc + PC_STEP;
    assign pc_target = align_addr(redirect_addr_in);

    mux_2_way #(.W(ARCH)) u_pc_mux (
        .sel (redirect_in),
        .d0  (pc_seq),
        .d1  (pc_target),
        .y   (pc_next)
    );

    // A response is kept only if nothing redirected while it was in flight.
    assign buf_load  = (state == WAIT) && imem_rvalid_in && !kill && !redirect_in;
    assign buf_clear = (state == HOLD) && (instr_ready_in || redirect_in);

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (buf_clear),
        .data_in (imem_rdata_in),
        .pc_in   (pc),
        .valid   (instr_valid_out),
        .data    (instr_out),
        .pc      (instr_pc_out),
        .pc_incr (instr_pc_incr_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            kill       <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_in && (redirect_addr_in[ALIGN_BITS-1:0] != '0);
            if (redirect_in || buf_load) begin
                pc <= pc_next;
            end
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt_in) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                        kill  <= redirect_in;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_in) begin
                        kill <= 1'b0;
                        if (kill || redirect_in) begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (redirect_in) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready_in || redirect_in) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_out  = req_q;
    assign imem_addr_out = pc;
    assign misalign_out  = misalign_q;
    assign dbg_state_out = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios plus a randomized run against a transaction-level fetch-stream model.
module tb_fetch_ctrl;
    import friscv_pkg::*;

    localparam logic [31:0] RV = 32'h0;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect;
    logic [31:0]  redirect_addr;
    logic         imem_req_out;
    logic [31:0]  imem_addr_out;
    logic         gnt;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         instr_valid_out;
    logic         ready;
    logic [31:0]  instr_out;
    logic [31:0]  instr_pc_out;
    logic [31:0]  instr_pc_incr_out;
    logic         misalign_out;
    fetch_state_t dbg_state_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_in       (redirect),
        .redirect_addr_in  (redirect_addr),
        .imem_req_out      (imem_req_out),
        .imem_addr_out     (imem_addr_out),
        .imem_gnt_in       (gnt),
        .imem_rvalid_in    (rvalid),
        .imem_rdata_in     (rdata),
        .instr_valid_out   (instr_valid_out),
        .instr_ready_in    (ready),
        .instr_out         (instr_out),
        .instr_pc_out      (instr_pc_out),
        .instr_pc_incr_out (instr_pc_incr_out),
        .misalign_out      (misalign_out),
        .dbg_state_out     (dbg_state_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task drive_idle();
        redirect = 1'b0; redirect_addr = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    endtask

    task do_fetch(input logic [31:0] d);
        gnt = 1'b1; cyc(); gnt = 1'b0;
        rvalid = 1'b1; rdata = d; cyc(); rvalid = 1'b0;
    endtask

    task test_reset();
        drive_idle(); rst = 1'b1;
        cyc(); cyc();
        n_cmp++; if (imem_req_out !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req_out); end
        n_cmp++; if (instr_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid_out); end
        n_cmp++; if (misalign_out !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign_out); end
        n_cmp++; if ({instr_out, instr_pc_out, instr_pc_incr_out} !== 96'h0) begin n_err++; $display("FAIL reset_buf: got %h %h %h want 0 0 0", instr_out, instr_pc_out, instr_pc_incr_out); end
        n_cmp++; if (dbg_state_out !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state_out); end
    endtask

    task test_first_fetch();
        rst = 1'b0; cyc();
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== RV) begin n_err++; $display("FAIL first_req: got %b %h want 1 %h", imem_req_out, imem_addr_out, RV); end
        cyc();
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== RV) begin n_err++; $display("FAIL first_req_hold: got %b %h want 1 %h", imem_req_out, imem_addr_out, RV); end
        gnt = 1'b1; cyc(); gnt = 1'b0;
        n_cmp++; if (imem_req_out !== 1'b0) begin n_err++; $display("FAIL first_wait_req: got %b want 0", imem_req_out); end
        cyc();
        n_cmp++; if (instr_valid_out !== 1'b0) begin n_err++; $display("FAIL first_early_valid: got %b want 0", instr_valid_out); end
        rvalid = 1'b1; rdata = 32'h0000_0013; cyc(); rvalid = 1'b0;
        n_cmp++; if (instr_valid_out !== 1'b1 || instr_out !== 32'h13) begin n_err++; $display("FAIL first_instr: got %b %h want 1 00000013", instr_valid_out, instr_out); end
        n_cmp++; if (instr_pc_out !== 32'h0 || instr_pc_incr_out !== 32'h4) begin n_err++; $display("FAIL first_pc: got %h %h want 0 4", instr_pc_out, instr_pc_incr_out); end
    endtask

    task test_hold_stall();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++;
            if (instr_valid_out !== 1'b1 || instr_out !== 32'h13 || instr_pc_out !== 32'h0 || imem_req_out !== 1'b0) begin
                n_err++; $display("FAIL hold_stall: got v=%b i=%h pc=%h req=%b want 1 00000013 0 0", instr_valid_out, instr_out, instr_pc_out, imem_req_out);
            end
        end
        ready = 1'b1; cyc(); ready = 1'b0;
        n_cmp++; if (instr_valid_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h4) begin n_err++; $display("FAIL hold_release: got v=%b req=%b a=%h want 0 1 4", instr_valid_out, imem_req_out, imem_addr_out); end
    endtask

    task test_redirect_wait();
        gnt = 1'b1; cyc(); gnt = 1'b0;
        redirect = 1'b1; redirect_addr = 32'h100; cyc(); redirect = 1'b0;
        n_cmp++; if (imem_req_out !== 1'b0 || instr_valid_out !== 1'b0) begin n_err++; $display("FAIL rdw_waiting: got req=%b v=%b want 0 0", imem_req_out, instr_valid_out); end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; cyc(); rvalid = 1'b0;
        n_cmp++; if (instr_valid_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h100) begin n_err++; $display("FAIL rdw_discard: got v=%b req=%b a=%h want 0 1 100", instr_valid_out, imem_req_out, imem_addr_out); end
        do_fetch(32'h11);
        n_cmp++; if (instr_valid_out !== 1'b1 || instr_out !== 32'h11 || instr_pc_out !== 32'h100) begin n_err++; $display("FAIL rdw_new: got v=%b i=%h pc=%h want 1 00000011 100", instr_valid_out, instr_out, instr_pc_out); end
        ready = 1'b1; cyc(); ready = 1'b0;
    endtask

    task test_misalign();
        redirect = 1'b1; redirect_addr = 32'h202; cyc(); redirect = 1'b0;
        n_cmp++; if (misalign_out !== 1'b1 || imem_addr_out !== 32'h200 || imem_req_out !== 1'b1) begin n_err++; $display("FAIL misalign_pulse: got m=%b a=%h req=%b want 1 200 1", misalign_out, imem_addr_out, imem_req_out); end
        cyc();
        n_cmp++; if (misalign_out !== 1'b0 || imem_addr_out !== 32'h200) begin n_err++; $display("FAIL misalign_end: got m=%b a=%h want 0 200", misalign_out, imem_addr_out); end
    endtask

    task test_wrap();
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; cyc(); redirect = 1'b0;
        n_cmp++; if (imem_addr_out !== 32'hFFFF_FFFC || misalign_out !== 1'b0) begin n_err++; $display("FAIL wrap_req: got a=%h m=%b want fffffffc 0", imem_addr_out, misalign_out); end
        do_fetch(32'h22);
        n_cmp++; if (instr_pc_out !== 32'hFFFF_FFFC || instr_pc_incr_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h %h want fffffffc 0", instr_pc_out, instr_pc_incr_out); end
        ready = 1'b1; cyc(); ready = 1'b0;
        n_cmp++; if (imem_addr_out !== 32'h0 || imem_req_out !== 1'b1) begin n_err++; $display("FAIL wrap_next: got a=%h req=%b want 0 1", imem_addr_out, imem_req_out); end
    endtask

    task test_redirect_hold();
        do_fetch(32'h33);
        ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h40; cyc();
        ready = 1'b0; redirect = 1'b0;
        n_cmp++; if (instr_valid_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== 32'h40) begin n_err++; $display("FAIL rdh: got v=%b req=%b a=%h want 0 1 40", instr_valid_out, imem_req_out, imem_addr_out); end
    endtask

    task test_reset_in_wait();
        gnt = 1'b1; cyc(); gnt = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++; if (imem_req_out !== 1'b0 || instr_valid_out !== 1'b0) begin n_err++; $display("FAIL rstw_idle: got req=%b v=%b want 0 0", imem_req_out, instr_valid_out); end
        rvalid = 1'b1; rdata = 32'h55; cyc(); rvalid = 1'b0;
        n_cmp++; if (instr_valid_out !== 1'b0 || imem_req_out !== 1'b1 || imem_addr_out !== RV) begin n_err++; $display("FAIL rstw_restart: got v=%b req=%b a=%h want 0 1 %h", instr_valid_out, imem_req_out, imem_addr_out, RV); end
        cyc();
        n_cmp++; if (instr_valid_out !== 1'b0) begin n_err++; $display("FAIL rstw_late: got v=%b want 0", instr_valid_out); end
    endtask

    // Model: the requested address stream follows model_pc; every redirect or reset
    // throws away all instructions requested before it.
    task test_random();
        logic [31:0] model_pc;
        logic [31:0] mem_addr;
        logic [31:0] tgt;
        logic        exp_mis;
        logic        mem_busy;
        logic        mem_live;
        int          mem_dly;
        int          accepted;
        drive_idle(); rst = 1'b1; cyc(); rst = 1'b0;
        exp_q.delete();
        model_pc = RV; exp_mis = 1'b0; mem_busy = 1'b0; mem_live = 1'b0;
        mem_addr = '0; mem_dly = 0; accepted = 0;
        for (int c = 0; c < 4000; c++) begin
            n_cmp++; if (misalign_out !== exp_mis) begin n_err++; $display("FAIL rnd_misalign c=%0d: got %b want %b", c, misalign_out, exp_mis); end
            if (imem_req_out) begin
                n_cmp++; if (imem_addr_out !== model_pc) begin n_err++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_addr_out, model_pc); end
                n_cmp++; if (mem_live || instr_valid_out) begin n_err++; $display("FAIL rnd_req_overlap c=%0d: got req with live=%b v=%b want neither", c, mem_live, instr_valid_out); end
            end
            if (instr_valid_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_killed_valid c=%0d: got valid pc=%h want no instruction", c, instr_pc_out);
                end else if (instr_pc_out !== exp_q[0] || instr_out !== mem_word(exp_q[0]) || instr_pc_incr_out !== exp_q[0] + 32'd4) begin
                    n_err++; $display("FAIL rnd_instr c=%0d: got %h/%h/%h want %h/%h/%h", c, instr_pc_out, instr_out, instr_pc_incr_out, exp_q[0], mem_word(exp_q[0]), exp_q[0] + 32'd4);
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            redirect = !rst && ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 2) == 0) tgt = tgt | 32'hFFFF_FFC0;
            if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
            redirect_addr = tgt;
            ready = 1'($urandom_range(0, 1));
            gnt = !rst && imem_req_out && !mem_busy && ($urandom_range(0, 9) < 6);
            rvalid = 1'b0;
            rdata = $urandom;
            if (mem_busy) begin
                if (mem_dly == 0) begin rvalid = 1'b1; rdata = mem_word(mem_addr); end
                else mem_dly--;
            end
            if (rvalid) begin mem_busy = 1'b0; mem_live = 1'b0; end
            if (rst) begin
                exp_q.delete(); model_pc = RV; exp_mis = 1'b0; mem_live = 1'b0;
            end else begin
                if (instr_valid_out && ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front()); accepted++;
                end
                if (gnt) begin
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                    mem_busy = 1'b1; mem_live = 1'b1; mem_addr = imem_addr_out;
                    mem_dly = $urandom_range(0, 2);
                end
                if (redirect) begin
                    exp_q.delete();
                    model_pc = {tgt[31:2], 2'b00};
                    exp_mis = (tgt[1:0] != 2'b00);
                end else begin
                    exp_mis = 1'b0;
                end
            end
            cyc();
        end
        rst = 1'b0; drive_idle();
        n_cmp++; if (accepted < 100) begin n_err++; $display("FAIL rnd_progress: got %0d accepted want >= 100", accepted); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_misalign();
        test_wrap();
        test_redirect_hold();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
